// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache line write-merge buffer.
package cache_pkg;
  localparam int LINE_BYTES = 32;
  localparam int OFFSET_W   = 5;
  localparam int LADDR_W    = 27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_DRAIN = 2'd2
  } wr_state_e;
endpackage

// File: rtl/offset_decoder.sv
// Byte offset to one-hot byte-enable decoder (combinational).
module offset_decoder
  import cache_pkg::*;
#(
  parameter int NBYTES = LINE_BYTES
) (
  input  logic [OFFSET_W-1:0] offset,
  output logic [NBYTES-1:0]   be
);
  for (genvar g = 0; g < NBYTES; g++) begin : g_be
    assign be[g] = (offset == OFFSET_W'(g));
  end
endmodule

// File: rtl/cache_line_writer.sv
// Merges byte stores to one cache line and offers the full/flushed line downstream.
module cache_line_writer
  import cache_pkg::*;
#(
  parameter int LINE_BYTES = cache_pkg::LINE_BYTES,
  parameter int LADDR_W    = cache_pkg::LADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [LADDR_W-1:0]      wr_line_addr,
  input  logic [OFFSET_W-1:0]     wr_offset,
  input  logic [7:0]              wr_byte,
  input  logic                    flush,
  output logic                    line_valid,
  input  logic                    line_ready,
  output logic [LADDR_W-1:0]      line_addr,
  output logic [LINE_BYTES*8-1:0] line_data,
  output logic [LINE_BYTES-1:0]   line_mask,
  output logic                    empty
);
  wr_state_e                         state;
  logic [LADDR_W-1:0]                addr_q;
  logic [LINE_BYTES-1:0]             mask_q, mask_nxt, be;
  logic [LINE_BYTES-1:0][7:0]        data_q, data_nxt;
  logic                              addr_hit, wr_fire;

  offset_decoder #(.NBYTES(LINE_BYTES)) u_dec (
    .offset (wr_offset),
    .be     (be)
  );

  assign addr_hit = (wr_line_addr == addr_q);
  assign wr_ready = (state == ST_IDLE) || (state == ST_MERGE && addr_hit);
  assign wr_fire  = wr_valid && wr_ready;

  // Buffer is zero while IDLE, so the same merge works for the first store.
  always_comb begin
    mask_nxt = mask_q | (wr_fire ? be : '0);
    data_nxt = data_q;
    for (int k = 0; k < LINE_BYTES; k++)
      if (wr_fire && be[k]) data_nxt[k] = wr_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      mask_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (wr_fire) begin
          addr_q <= wr_line_addr;
          mask_q <= mask_nxt;
          data_q <= data_nxt;
          state  <= ST_MERGE;
        end
        ST_MERGE: begin
          mask_q <= mask_nxt;
          data_q <= data_nxt;
          // A mismatching store is held off; it is accepted after the drain.
          if ((&mask_nxt) || flush || (wr_valid && !addr_hit))
            state <= ST_DRAIN;
        end
        ST_DRAIN: if (line_ready) begin
          mask_q <= '0;
          data_q <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign line_valid = (state == ST_DRAIN);
  assign empty      = (state == ST_IDLE);
  assign line_addr  = addr_q;
  assign line_data  = data_q;
  assign line_mask  = mask_q;
endmodule

// File: tb/tb_cache_line_writer.sv
// Directed self-checking bench for cache_line_writer.
module tb_cache_line_writer;
  localparam int LADDR_W = 27;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_valid, wr_ready, flush, line_valid, line_ready, empty;
  logic [LADDR_W-1:0] wr_line_addr, line_addr;
  logic [4:0]         wr_offset;
  logic [7:0]         wr_byte;
  logic [255:0]       line_data, exp_data;
  logic [31:0]        line_mask;
  logic [255:0]       snap_data;
  int                 errors = 0;
  int                 checks = 0;

  cache_line_writer #(.LINE_BYTES(32), .LADDR_W(LADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_line_addr (wr_line_addr),
    .wr_offset    (wr_offset),
    .wr_byte      (wr_byte),
    .flush        (flush),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .line_addr    (line_addr),
    .line_data    (line_data),
    .line_mask    (line_mask),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [LADDR_W-1:0] a, input logic [4:0] o, input logic [7:0] b);
    wr_valid = 1'b1; wr_line_addr = a; wr_offset = o; wr_byte = b;
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_line_addr = '0; wr_offset = '0;
    wr_byte = '0; flush = 1'b0; line_ready = 1'b0;
    #12;
    chk("rst_line_valid", 256'(line_valid), 256'd0);
    chk("rst_mask", 256'(line_mask), 256'd0);
    chk("rst_data", line_data, 256'd0);
    chk("rst_addr", 256'(line_addr), 256'd0);
    chk("rst_empty", 256'(empty), 256'd1);
    rst_n = 1'b1;
    tick();
    chk("rel_wr_ready", 256'(wr_ready), 256'd1);

    // Flush in IDLE is ignored.
    flush = 1'b1; tick(); flush = 1'b0;
    chk("idle_flush_empty", 256'(empty), 256'd1);

    // Full line 0x100, bytes 0xA0+k.
    exp_data = '0;
    for (int k = 0; k < 32; k++) begin
      store(27'h100, 5'(k), 8'(8'hA0 + k));
      exp_data[8*k +: 8] = 8'(8'hA0 + k);
      #1;
      chk($sformatf("full_wr_ready_%0d", k), 256'(wr_ready), 256'd1);
      if (k == 31) chk("full_pre_line_valid", 256'(line_valid), 256'd0);
      tick();
    end
    wr_valid = 1'b0;
    chk("full_line_valid", 256'(line_valid), 256'd1);
    chk("full_mask", 256'(line_mask), 256'hFFFFFFFF);
    chk("full_data", line_data, exp_data);
    chk("full_addr", 256'(line_addr), 256'h100);
    chk("full_drain_wr_ready", 256'(wr_ready), 256'd0);
    line_ready = 1'b1; tick(); line_ready = 1'b0;
    chk("full_hs_empty", 256'(empty), 256'd1);
    chk("full_hs_mask", 256'(line_mask), 256'd0);
    chk("full_hs_data", line_data, 256'd0);

    // Overwrite byte 3 then flush.
    store(27'h5, 5'd3, 8'h11); tick();
    store(27'h5, 5'd3, 8'h22); tick();
    wr_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
    chk("ovw_line_valid", 256'(line_valid), 256'd1);
    chk("ovw_mask", 256'(line_mask), 256'h8);
    chk("ovw_data", line_data, 256'h22000000);
    line_ready = 1'b1; tick(); line_ready = 1'b0;

    // Flush together with a same-address store: the store is merged.
    store(27'h7, 5'd0, 8'h33); tick();
    store(27'h7, 5'd1, 8'h44); flush = 1'b1; #1;
    chk("fs_wr_ready", 256'(wr_ready), 256'd1);
    tick(); wr_valid = 1'b0; flush = 1'b0;
    chk("fs_line_valid", 256'(line_valid), 256'd1);
    chk("fs_mask", 256'(line_mask), 256'h3);
    chk("fs_data", line_data, 256'h4433);
    line_ready = 1'b1; tick(); line_ready = 1'b0;

    // Address change forces a drain; the held-off store survives back-pressure.
    store(27'h5, 5'd2, 8'h55); tick();
    store(27'h6, 5'd4, 8'h66); #1;
    chk("mis_wr_ready", 256'(wr_ready), 256'd0);
    tick();
    chk("mis_line_valid", 256'(line_valid), 256'd1);
    chk("mis_addr", 256'(line_addr), 256'h5);
    chk("mis_mask", 256'(line_mask), 256'h4);
    chk("mis_data", line_data, 256'h550000);
    snap_data = line_data;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("bp_valid_%0d", c), 256'(line_valid), 256'd1);
      chk($sformatf("bp_wr_ready_%0d", c), 256'(wr_ready), 256'd0);
      chk($sformatf("bp_data_%0d", c), line_data, snap_data);
      chk($sformatf("bp_mask_%0d", c), 256'(line_mask), 256'h4);
    end
    line_ready = 1'b1; #1;
    chk("hs_wr_ready", 256'(wr_ready), 256'd0);
    tick(); line_ready = 1'b0;
    chk("post_hs_empty", 256'(empty), 256'd1);
    chk("post_hs_wr_ready", 256'(wr_ready), 256'd1);
    tick(); wr_valid = 1'b0;
    chk("new_addr", 256'(line_addr), 256'h6);
    chk("new_mask", 256'(line_mask), 256'h10);
    chk("new_data", line_data, 256'h66_00000000);
    chk("new_line_valid", 256'(line_valid), 256'd0);
    chk("new_empty", 256'(empty), 256'd0);

    // Reset mid-drain discards the line.
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pre_rst_valid", 256'(line_valid), 256'd1);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_valid", 256'(line_valid), 256'd0);
    chk("mid_rst_mask", 256'(line_mask), 256'd0);
    chk("mid_rst_empty", 256'(empty), 256'd1);
    chk("mid_rst_data", line_data, 256'd0);
    tick(); rst_n = 1'b1; tick();
    chk("after_rst_wr_ready", 256'(wr_ready), 256'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_line_writer.md
CACHE_LINE_WRITER -- requirements
Module: cache_line_writer

Interface
REQ-001 Parameter LINE_BYTES, default 32, bytes per cache line; fixed at 32 for this release.
REQ-002 Parameter LADDR_W, default 27, line-address width (32-bit byte address minus 5 offset bits).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_valid  input  1  byte store offered.
REQ-006 wr_ready  output  1  byte store accepted when wr_valid && wr_ready at a rising edge.
REQ-007 wr_line_addr  input  LADDR_W  line address of the store.
REQ-008 wr_offset  input  5  byte offset in line; offset k maps to line_data[8k+7:8k].
REQ-009 wr_byte  input  8  store data.
REQ-010 flush  input  1  request to drain a partial line; level, sampled each cycle.
REQ-011 line_valid  output  1  merged line offered to the data array.
REQ-012 line_ready  input  1  data array accepts the line when line_valid && line_ready.
REQ-013 line_addr  output  LADDR_W  address of the offered line.
REQ-014 line_data  output  256  merged line; unwritten bytes read 0.
REQ-015 line_mask  output  32  byte enables; bit k set if byte k written.
REQ-016 empty  output  1  high when no line is buffered (state IDLE).

Function
REQ-017 States: IDLE (buffer empty), MERGE (partial line held), DRAIN (line offered).
REQ-018 IDLE: wr_ready=1; accepted store captures wr_line_addr, writes byte, sets its mask bit, next MERGE; flush ignored.
REQ-019 MERGE: wr_ready=1 only when wr_line_addr equals held address; otherwise wr_ready=0 and next DRAIN (store held off, not lost).
REQ-020 MERGE same-address store overwrites the byte at wr_offset, sets its mask bit; rewriting a set byte keeps mask unchanged.
REQ-021 MERGE -> DRAIN when, after the current-cycle merge, mask is all ones, or flush=1, or an address mismatch is offered.
REQ-022 Simultaneous flush and same-address store in MERGE: store accepted and merged, then DRAIN with merged contents.
REQ-023 DRAIN: line_valid=1, wr_ready=0; line_addr/line_data/line_mask stable until handshake.
REQ-024 DRAIN handshake: next cycle mask and data cleared to 0, state IDLE; no store accepted in the handshake cycle.
REQ-025 Latency: store completing the line at edge N gives line_valid=1 in cycle N+1; flush sampled at edge N gives line_valid=1 in cycle N+1.
REQ-026 line_valid outside DRAIN is 0; line_* outputs reflect buffer contents in all states.
REQ-027 wr_ready is combinational from state, held address and wr_line_addr; no dependency on line_ready.

Reset
REQ-028 rst_n low asynchronously forces state IDLE, line_valid=0, line_mask=0, line_data=0, line_addr=0, empty=1; wr_ready=1 after release.
REQ-029 Reset during DRAIN or MERGE discards the buffered line without handshake.

Structure
REQ-030 Shared package cache_pkg holds LINE_BYTES, OFFSET_W=5, LADDR_W and the writer state enum.
REQ-031 One sub-module, offset_decoder: 5-bit offset -> 32-bit one-hot byte enable, purely combinational.

Verification
REQ-032 Reset, then stores 0xA0+k at offsets 0..31 of line 0x100 back-to-back -> line_valid in cycle after 32nd store, line_mask=0xFFFFFFFF, byte k=0xA0+k.
REQ-033 Stores 0x11@off3, 0x22@off3 on line 0x5, then flush -> line_mask=0x00000008, byte3=0x22, others 0.
REQ-034 Store on line 0x5 then store on line 0x6 -> wr_ready=0 for 0x6, DRAIN line 0x5; after line_ready, 0x6 accepted, new mask has only its bit.
REQ-035 line_ready held low 10 cycles in DRAIN with wr_valid=1 -> outputs stable, wr_ready=0 throughout, no store lost.
REQ-036 rst_n asserted mid-DRAIN -> line_valid=0 and mask=0 immediately, empty=1.
